alu_arbiter: RTL and testbench

//  Shares one registered ALU (1-cycle result latency, cin=1 selects a-b) among NUM_REQ requesters.

---
 rtl/alu_arbiter.sv | 144 ++++++++++++++
 tb/tb_alu_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered ALU (1-cycle latency) among NUM_REQ requesters.
// Optional grant lock per requester is compiled in with `define ALU_ARB_LOCK_EN (adds port req_lock).
module alu_arbiter #(
   parameter int DATA_BITS = 8,
   parameter int NUM_REQ   = 2
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*DATA_BITS-1:0] req_a,
   input  logic [NUM_REQ*DATA_BITS-1:0] req_b,
   input  logic [NUM_REQ-1:0]           req_sub,
`ifdef ALU_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]           req_lock,
`endif
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [DATA_BITS-1:0]         rsp_result,
   output logic                         rsp_cout,
   output logic                         rsp_zero,
   output logic [DATA_BITS-1:0]         alu_a,
   output logic [DATA_BITS-1:0]         alu_b,
   output logic                         alu_cin,
   input  logic [DATA_BITS-1:0]         alu_result,
   input  logic                         alu_cout
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SUM_W = IDX_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [SUM_W-1:0] NUM_REQ_W = SUM_W'(NUM_REQ);

   logic [IDX_W-1:0] rr_ptr_q;
   logic [IDX_W-1:0] rr_ptr_d;
   logic             inflight_q;
   logic             inflight_d;
   logic [IDX_W-1:0] tag_q;
   logic [IDX_W-1:0] tag_d;

   logic             grant_vld_s;
   logic [IDX_W-1:0] grant_idx_s;
   logic             hit_s;
   logic [SUM_W-1:0] sum_s;
   logic [IDX_W-1:0] cand_s;

`ifdef ALU_ARB_LOCK_EN
   logic             lock_q;
   logic             lock_d;
   logic [IDX_W-1:0] lock_idx_q;
   logic [IDX_W-1:0] lock_idx_d;
   logic             lock_hit_s;
`endif

   // Winner selection: first valid requester after rr_ptr, overridden by a held lock.
   always_comb begin
      grant_vld_s = 1'b0;
      grant_idx_s = '0;
      hit_s       = 1'b0;
      sum_s       = '0;
      cand_s      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum_s       = {1'b0, rr_ptr_q} + SUM_W'(k);
         sum_s       = (sum_s >= NUM_REQ_W) ? (sum_s - NUM_REQ_W) : sum_s;
         cand_s      = sum_s[IDX_W-1:0];
         hit_s       = !grant_vld_s && req_valid[cand_s];
         grant_idx_s = hit_s ? cand_s : grant_idx_s;
         grant_vld_s = grant_vld_s | hit_s;
      end
`ifdef ALU_ARB_LOCK_EN
      lock_hit_s  = lock_q && req_valid[lock_idx_q] && req_lock[lock_idx_q];
      grant_idx_s = lock_hit_s ? lock_idx_q : grant_idx_s;
      grant_vld_s = grant_vld_s | lock_hit_s;
`endif
      grant_vld_s = grant_vld_s & reset_n;
   end

   // Grant vector and ALU operand mux; everything is zero when nothing is granted.
   always_comb begin
      req_ready = '0;
      alu_a     = '0;
      alu_b     = '0;
      alu_cin   = 1'b0;
      if (grant_vld_s) begin
         req_ready[grant_idx_s] = 1'b1;
         alu_a   = req_a[int'(grant_idx_s)*DATA_BITS +: DATA_BITS];
         alu_b   = req_b[int'(grant_idx_s)*DATA_BITS +: DATA_BITS];
         alu_cin = req_sub[grant_idx_s];
      end else begin
         req_ready = '0;
      end
   end

   // Next-state: remember the winner so its result can be routed back one cycle later.
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      tag_d      = tag_q;
      inflight_d = grant_vld_s;
      if (grant_vld_s) begin
         rr_ptr_d = grant_idx_s;
         tag_d    = grant_idx_s;
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
`ifdef ALU_ARB_LOCK_EN
      lock_d     = grant_vld_s & req_lock[grant_idx_s];
      lock_idx_d = grant_vld_s ? grant_idx_s : lock_idx_q;
`endif
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_ptr_q   <= LAST_IDX;
         inflight_q <= 1'b0;
         tag_q      <= '0;
`ifdef ALU_ARB_LOCK_EN
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
`endif
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
`ifdef ALU_ARB_LOCK_EN
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
`endif
      end
   end

   // Response routing: the ALU result lands one cycle after the grant.
   always_comb begin
      rsp_valid  = '0;
      rsp_result = alu_result;
      rsp_cout   = alu_cout;
      rsp_zero   = ~|alu_result;
      if (inflight_q && reset_n) begin
         rsp_valid[tag_q] = 1'b1;
      end else begin
         rsp_valid = '0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// against a queue-free arithmetic reference model; includes a registered ALU model.
module tb_alu_arbiter;

   localparam int DB = 8;
   localparam int NR = 2;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NR-1:0]     req_valid;
   logic [NR*DB-1:0]  req_a;
   logic [NR*DB-1:0]  req_b;
   logic [NR-1:0]     req_sub;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     rsp_valid;
   logic [DB-1:0]     rsp_result;
   logic              rsp_cout;
   logic              rsp_zero;
   logic [DB-1:0]     alu_a;
   logic [DB-1:0]     alu_b;
   logic              alu_cin;
   logic [DB-1:0]     alu_result;
   logic              alu_cout;
`ifdef ALU_ARB_LOCK_EN
   logic [NR-1:0]     req_lock;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   // Registered ALU: cin=1 computes a + ~b + 1.
   always_ff @(posedge clk) begin
      {alu_cout, alu_result} <= alu_cin ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1)
                                        : ({1'b0, alu_a} + {1'b0, alu_b});
   end

   alu_arbiter #(.DATA_BITS(DB), .NUM_REQ(NR)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_sub    (req_sub),
`ifdef ALU_ARB_LOCK_EN
      .req_lock   (req_lock),
`endif
      .req_ready  (req_ready),
      .rsp_valid  (rsp_valid),
      .rsp_result (rsp_result),
      .rsp_cout   (rsp_cout),
      .rsp_zero   (rsp_zero),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_cin    (alu_cin),
      .alu_result (alu_result),
      .alu_cout   (alu_cout)
   );

   // Reference arithmetic in plain integers: {cout, result}.
   function automatic logic [DB:0] ref_alu(input int a, input int b, input bit sub);
      int full;
      int r;
      full = 1 << DB;
      if (sub) begin
         r = a - b + full;
         return {(a >= b) ? 1'b1 : 1'b0, DB'(r % full)};
      end
      r = a + b;
      return {(r >= full) ? 1'b1 : 1'b0, DB'(r % full)};
   endfunction

   task automatic test_reset();
      reset_n   = 1'b0;
      req_valid = '1;
      req_a     = {8'h12, 8'h34};
      req_b     = {8'h56, 8'h78};
      req_sub   = 2'b01;
      repeat (2) begin
         #1;
         tests_run++;
         if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || alu_a !== 8'h00 ||
             alu_b !== 8'h00 || alu_cin !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got ready=%b rsp=%b a=%h b=%h cin=%b want all zero",
                     req_ready, rsp_valid, alu_a, alu_b, alu_cin);
         end
         @(posedge clk); #1;
         tests_run++;
         if (rsp_valid !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_rsp: got %b want 00", rsp_valid);
         end
      end
      reset_n   = 1'b1;
      req_valid = '0;
   endtask

   task automatic test_single();
      req_valid = 2'b01;
      req_a     = {8'hAA, 8'h0F};
      req_b     = {8'hBB, 8'h01};
      req_sub   = 2'b10;
      #1;
      tests_run++;
      if (req_ready !== 2'b01 || alu_a !== 8'h0F || alu_b !== 8'h01 || alu_cin !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_grant: got ready=%b a=%h b=%h cin=%b want 01 0f 01 0",
                  req_ready, alu_a, alu_b, alu_cin);
      end
      @(posedge clk); #1;
      req_valid = '0;
      tests_run++;
      if (rsp_valid !== 2'b01 || rsp_result !== 8'h10 || rsp_cout !== 1'b0 || rsp_zero !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_rsp: got v=%b r=%h c=%b z=%b want 01 10 0 0",
                  rsp_valid, rsp_result, rsp_cout, rsp_zero);
      end
      #1;
      tests_run++;
      if (req_ready !== 2'b00) begin
         tests_failed++;
         $display("FAIL idle_ready: got %b want 00", req_ready);
      end
      @(posedge clk); #1;
      tests_run++;
      if (rsp_valid !== 2'b00) begin
         tests_failed++;
         $display("FAIL idle_rsp: got %b want 00", rsp_valid);
      end
   endtask

   task automatic test_alternate();
      logic [NR-1:0] exp_g;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n   = 1'b1;
      req_valid = 2'b11;
      for (int c = 0; c < 6; c++) begin
         exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         tests_run++;
         if (req_ready !== exp_g) begin
            tests_failed++;
            $display("FAIL alt_grant[%0d]: got %b want %b", c, req_ready, exp_g);
         end
         @(posedge clk); #1;
         tests_run++;
         if (rsp_valid !== exp_g) begin
            tests_failed++;
            $display("FAIL alt_rsp[%0d]: got %b want %b", c, rsp_valid, exp_g);
         end
      end
      req_valid = '0;
   endtask

   task automatic test_arith();
      logic [DB-1:0] ta [4];
      logic [DB-1:0] tb [4];
      logic          ts [4];
      logic [DB-1:0] tr [4];
      logic          tc [4];
      ta[0] = 8'h05; tb[0] = 8'h05; ts[0] = 1'b1; tr[0] = 8'h00; tc[0] = 1'b1;
      ta[1] = 8'hFF; tb[1] = 8'h01; ts[1] = 1'b0; tr[1] = 8'h00; tc[1] = 1'b1;
      ta[2] = 8'h03; tb[2] = 8'h05; ts[2] = 1'b1; tr[2] = 8'hFE; tc[2] = 1'b0;
      ta[3] = 8'h80; tb[3] = 8'h01; ts[3] = 1'b0; tr[3] = 8'h81; tc[3] = 1'b0;
      req_valid = 2'b10;
      for (int i = 0; i < 4; i++) begin
         req_a[DB +: DB] = ta[i];
         req_b[DB +: DB] = tb[i];
         req_sub[1]      = ts[i];
         #1;
         tests_run++;
         if (req_ready !== 2'b10 || alu_cin !== ts[i]) begin
            tests_failed++;
            $display("FAIL arith_grant[%0d]: got ready=%b cin=%b want 10 %b", i, req_ready, alu_cin, ts[i]);
         end
         @(posedge clk); #1;
         tests_run++;
         if (rsp_valid !== 2'b10 || rsp_result !== tr[i] || rsp_cout !== tc[i] ||
             rsp_zero !== (tr[i] == 8'h00)) begin
            tests_failed++;
            $display("FAIL arith_rsp[%0d]: got v=%b r=%h c=%b z=%b want 10 %h %b %b",
                     i, rsp_valid, rsp_result, rsp_cout, rsp_zero, tr[i], tc[i], tr[i] == 8'h00);
         end
      end
      req_valid = '0;
   endtask

   task automatic test_reset_mid();
      req_valid = 2'b01;
      req_a     = {8'h02, 8'h40};
      req_b     = {8'h01, 8'h02};
      req_sub   = 2'b00;
      #1;
      tests_run++;
      if (req_ready !== 2'b01) begin
         tests_failed++;
         $display("FAIL mid_grant: got %b want 01", req_ready);
      end
      @(posedge clk); #1;
      reset_n   = 1'b0;
      req_valid = 2'b11;
      #1;
      tests_run++;
      if (req_ready !== 2'b00 || rsp_valid !== 2'b00) begin
         tests_failed++;
         $display("FAIL mid_in_reset: got ready=%b rsp=%b want 00 00", req_ready, rsp_valid);
      end
      @(posedge clk); #1;
      reset_n = 1'b1;
      tests_run++;
      if (rsp_valid !== 2'b00) begin
         tests_failed++;
         $display("FAIL mid_dropped: got %b want 00", rsp_valid);
      end
      #1;
      tests_run++;
      if (req_ready !== 2'b01) begin
         tests_failed++;
         $display("FAIL mid_first_grant: got %b want 01", req_ready);
      end
      @(posedge clk); #1;
      tests_run++;
      if (rsp_valid !== 2'b01 || rsp_result !== 8'h42) begin
         tests_failed++;
         $display("FAIL mid_rsp: got v=%b r=%h want 01 42", rsp_valid, rsp_result);
      end
      req_valid = '0;
   endtask

`ifdef ALU_ARB_LOCK_EN
   task automatic test_lock();
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n   = 1'b1;
      req_valid = 2'b11;
      req_lock  = 2'b01;
      for (int c = 0; c < 3; c++) begin
         #1;
         tests_run++;
         if (req_ready !== 2'b01) begin
            tests_failed++;
            $display("FAIL lock_hold[%0d]: got %b want 01", c, req_ready);
         end
         @(posedge clk); #1;
      end
      req_lock = 2'b00;
      #1;
      tests_run++;
      if (req_ready !== 2'b10) begin
         tests_failed++;
         $display("FAIL lock_release: got %b want 10", req_ready);
      end
      @(posedge clk); #1;
      req_valid = '0;
   endtask
`endif

   task automatic test_random();
      logic [DB-1:0] pa [NR];
      logic [DB-1:0] pb [NR];
      bit            ps [NR];
      bit            pv [NR];
      int            waitc [NR];
      int            last;
      int            g;
      int            idx;
      logic [NR-1:0] exp_g;
      logic [DB:0]   exp_o;
      reset_n   = 1'b0;
      req_valid = '0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      last    = NR - 1;
      for (int i = 0; i < NR; i++) begin
         pv[i] = 1'b0;
         waitc[i] = 0;
      end
      repeat (400) begin
         for (int i = 0; i < NR; i++) begin
            if (!pv[i]) begin
               pv[i] = ($urandom_range(0, 3) != 0);
               pa[i] = DB'($urandom);
               pb[i] = DB'($urandom);
               ps[i] = ($urandom_range(0, 1) == 1);
            end
            req_valid[i]        = pv[i];
            req_a[i*DB +: DB]   = pa[i];
            req_b[i*DB +: DB]   = pb[i];
            req_sub[i]          = ps[i];
         end
         #1;
         g = -1;
         for (int k = 1; k <= NR; k++) begin
            idx = (last + k) % NR;
            if (g < 0 && pv[idx]) g = idx;
         end
         exp_g = (g >= 0) ? (NR'(1) << g) : '0;
         exp_o = '0;
         tests_run++;
         if (req_ready !== exp_g) begin
            tests_failed++;
            $display("FAIL rand_grant: got %b want %b", req_ready, exp_g);
         end
         if (g >= 0) begin
            tests_run++;
            if (alu_a !== pa[g] || alu_b !== pb[g] || alu_cin !== ps[g]) begin
               tests_failed++;
               $display("FAIL rand_operands: got %h %h %b want %h %h %b",
                        alu_a, alu_b, alu_cin, pa[g], pb[g], ps[g]);
            end
            exp_o    = ref_alu(int'(pa[g]), int'(pb[g]), ps[g]);
            last     = g;
            pv[g]    = 1'b0;
            waitc[g] = 0;
         end
         for (int i = 0; i < NR; i++) begin
            if (pv[i]) begin
               waitc[i]++;
               tests_run++;
               if (waitc[i] > NR - 1) begin
                  tests_failed++;
                  $display("FAIL rand_starve[%0d]: waited %0d want <= %0d", i, waitc[i], NR - 1);
               end
            end
         end
         @(posedge clk); #1;
         tests_run++;
         if (rsp_valid !== exp_g) begin
            tests_failed++;
            $display("FAIL rand_rsp_valid: got %b want %b", rsp_valid, exp_g);
         end
         if (g >= 0) begin
            tests_run++;
            if ({rsp_cout, rsp_result} !== exp_o || rsp_zero !== (exp_o[DB-1:0] == '0)) begin
               tests_failed++;
               $display("FAIL rand_rsp_data: got c=%b r=%h z=%b want c=%b r=%h",
                        rsp_cout, rsp_result, rsp_zero, exp_o[DB], exp_o[DB-1:0]);
            end
         end
      end
      req_valid = '0;
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      req_sub   = '0;
`ifdef ALU_ARB_LOCK_EN
      req_lock  = '0;
`endif
      test_reset();
      test_single();
      test_alternate();
      test_arith();
      test_reset_mid();
`ifdef ALU_ARB_LOCK_EN
      test_lock();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
